muacm_in_packer: RTL and testbench
==================================

Name: muacm_in_packer

Overview:
- Transmit-side packetizer that feeds the muacm IN (device-to-host) byte pipe from user logic.
- Buffers user bytes in a local FIFO and forms bounded packets, marking the final byte with in_last.
- A packet closes on three triggers: maximum size reached, an idle timeout, or an explicit user flush.
- Drives in_flush_now / in_flush_time so short packets do not sit in the muacm buffer.

Parameters:
- FIFO_LOG2, 8, log2 of FIFO depth (256 bytes); must satisfy 2^FIFO_LOG2 >= MAX_PKT.
- MAX_PKT, 64, maximum bytes per packet, range 1..2^FIFO_LOG2.
- TIMEOUT, 4800, idle cycles (100 us at 48 MHz) after the last accepted byte before a short packet is forced; 0 disables the timeout.
- FLUSH_TIME, 1, constant value driven on in_flush_time.

Ports:
- clk, input, 1, clock (USB 48 MHz domain).
- rst, input, 1, reset; synchronous, active-high.
- s_data, input, 8, user byte.
- s_valid, input, 1, user byte valid.
- s_ready, output, 1, FIFO can accept a byte.
- s_flush, input, 1, single-cycle request: close the current packet and flush the host side.
- in_data, output, 8, byte to muacm.
- in_last, output, 1, final byte of the packet.
- in_valid, output, 1, in_data valid.
- in_ready, input, 1, muacm accepts the byte.
- in_flush_now, output, 1, one-cycle flush pulse to muacm.
- in_flush_time, output, 1, tied to FLUSH_TIME.

Behaviour:
- Reset values: s_ready=0 during rst, 1 in the cycle after. in_valid=0, in_last=0, in_flush_now=0. FIFO empty, timer=0, flush_pend=0, state=IDLE.
- User side:
  - A byte is accepted when s_valid&&s_ready.
  - s_ready = !fifo_full.
  - Accepted data is visible to the FIFO read port 1 cycle later.
- level: FIFO_LOG2+1 bits. Increments on write, decrements on read, unchanged when both happen in the same cycle.
- s_flush:
  - Sets flush_pend whenever asserted, whether or not a byte is written in the same cycle.
  - Is ignored while flush_pend is already set (no double pulse).
- Timer:
  - Clears on every accepted byte and on leaving SEND.
  - Otherwise increments while state=ACCUM, saturating at TIMEOUT.
- IDLE:
  - level>0 -> ACCUM.
  - flush_pend && level==0 -> FLUSH (empty flush still pulses in_flush_now).
- ACCUM: latch pkt_len = min(level, MAX_PKT) and go to SEND when any of these holds:
  - level>=MAX_PKT;
  - flush_pend;
  - TIMEOUT!=0 && timer==TIMEOUT.
  - Check priority is MAX_PKT first, then flush_pend, then timeout.
- SEND:
  - in_valid=1 with in_data from the FIFO head.
  - Down-counter cnt loaded with pkt_len; one byte transfers per in_valid&&in_ready cycle.
  - in_last=1 exactly when cnt==1.
  - in_valid/in_data/in_last hold stable while in_ready=0.
  - On the last transfer:
    - flush_pend=1 and FIFO holds no further byte -> FLUSH.
    - else level(after read)>0 -> ACCUM.
    - else -> IDLE.
- FLUSH: in_flush_now=1 for exactly one cycle, flush_pend cleared, then -> IDLE or ACCUM depending on level.
- pkt_len and cnt: width $clog2(MAX_PKT+1). Bytes written during SEND are never added to the current packet.
- Boundaries:
  - FIFO full: s_ready=0, and the full condition forces level>=MAX_PKT, so a packet always drains.
  - Simultaneous write and read at level==1 keeps level at 1.
  - s_flush arriving during SEND applies after the current packet.
  - MAX_PKT=1: every byte carries in_last.
  - rst mid-packet: the FIFO is discarded and in_valid drops in the next cycle with no in_last emitted. The downstream muacm shares rst, so the truncation is acceptable.

Decomposition:
- Package muacm_pkg holds:
  - state encoding (IDLE, ACCUM, SEND, FLUSH);
  - the default MAX_PKT=64 constant;
  - the 48 MHz cycles-per-microsecond constant used to derive TIMEOUT.
- One sub-module, fifo_sync_ram: parameterized synchronous FIFO with first-word-fall-through read, full/empty/level outputs, single clk/rst.
- The FSM, timer and counters live in muacm_in_packer.

Test Plan:
- 64 back-to-back bytes 0x00..0x3F, in_ready=1: one packet, in_last on 0x3F only, no in_flush_now.
- 3 bytes 0xA1,0xA2,0xA3 then idle, TIMEOUT=100: packet of 3 emitted about 100 cycles after 0xA3, with in_last on 0xA3.
- 5 bytes, s_flush asserted with the 5th byte: packet of 5, in_last on the 5th, in_flush_now high exactly 1 cycle after that transfer.
- 300 bytes with in_ready=0 throughout:
  - s_ready falls after byte 256 is accepted;
  - releasing in_ready yields packets of 64,64,64,64,44 in order with data intact.
- Random in_ready stalls (about 50%) on a 130-byte stream: output equals input with in_last at byte indices 63, 127 and 129 (the last via timeout).
- rst asserted mid-SEND after 10 of 64 bytes: in_valid=0 on the next cycle; level=0. Then:
  - a following s_flush gives a single in_flush_now pulse with no data;
  - a following 2-byte write with timeout emits a 2-byte packet.

Source files
------------

// File: rtl/muacm_pkg.sv
// Shared constants and state encoding for the muacm IN-side packetizer.
package muacm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SEND  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int MAX_PKT_DEFAULT = 64;
  localparam int CYCLES_PER_US   = 48;
  // 100 us of idle at the 48 MHz USB clock.
  localparam int TIMEOUT_DEFAULT = 100 * CYCLES_PER_US;

endpackage

// File: rtl/fifo_sync_ram.sv
// Synchronous FIFO with first-word-fall-through read; a written word is
// visible on rd_data one cycle after the write.
module fifo_sync_ram #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LOG2:0]    level
);

  localparam logic [LOG2:0]   DEPTH   = (LOG2+1)'(1 << LOG2);
  localparam logic [LOG2:0]   LVL_ONE = (LOG2+1)'(1);
  localparam logic [LOG2-1:0] PTR_ONE = LOG2'(1);

  logic [WIDTH-1:0] mem [0:(1 << LOG2)-1];
  logic [LOG2-1:0]  wr_ptr;
  logic [LOG2-1:0]  rd_ptr;
  logic             wr;
  logic             rd;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr, rd})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/muacm_in_packer.sv
// Packetizer feeding the muacm IN byte pipe: buffers user bytes and closes
// packets on max size, idle timeout or user flush.
//
//   state    | meaning
//   ST_IDLE  | FIFO empty, nothing pending
//   ST_ACCUM | bytes buffered, waiting for a close trigger
//   ST_SEND  | streaming a latched-length packet to muacm
//   ST_FLUSH | one-cycle in_flush_now pulse
module muacm_in_packer import muacm_pkg::*; #(
  parameter int   FIFO_LOG2  = 8,
  parameter int   MAX_PKT    = MAX_PKT_DEFAULT,
  parameter int   TIMEOUT    = TIMEOUT_DEFAULT,
  parameter logic FLUSH_TIME = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_flush,
  output logic [7:0] in_data,
  output logic       in_last,
  output logic       in_valid,
  input  logic       in_ready,
  output logic       in_flush_now,
  output logic       in_flush_time
);

  localparam int CNT_W   = $clog2(MAX_PKT + 1);
  localparam int TIMER_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [FIFO_LOG2:0] MAX_LVL   = (FIFO_LOG2+1)'(MAX_PKT);
  localparam logic [FIFO_LOG2:0] LVL_ONE   = (FIFO_LOG2+1)'(1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_PKT);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] TMR_ONE   = TIMER_W'(1);

  state_t             state;
  state_t             state_next;
  logic               flush_pend;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   pkt_len;
  logic [FIFO_LOG2:0] level;
  logic [FIFO_LOG2:0] level_after;
  logic               full;
  logic               empty;
  logic               accept;
  logic               rd;
  logic               xfer_last;
  logic               timeout_hit;
  logic               go_send;

  fifo_sync_ram #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (s_data),
    .rd_en   (rd),
    .rd_data (in_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign s_ready       = !full && !rst;
  assign accept        = s_valid && s_ready;
  assign in_valid      = (state == ST_SEND) && !empty;
  assign in_last       = (state == ST_SEND) && (cnt == CNT_ONE);
  assign rd            = in_valid && in_ready;
  assign xfer_last     = rd && (cnt == CNT_ONE);
  assign timeout_hit   = (TIMEOUT != 0) && (timer == TIMEOUT_V);
  assign in_flush_time = FLUSH_TIME;

  // Occupancy once this cycle's read and write have landed.
  assign level_after = level - LVL_ONE + (accept ? LVL_ONE : '0);
  assign pkt_len     = (level >= MAX_LVL) ? MAX_CNT : CNT_W'(level);

  always_comb begin
    state_next   = state;
    go_send      = 1'b0;
    in_flush_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level != '0)     state_next = ST_ACCUM;
        else if (flush_pend) state_next = ST_FLUSH;
      end
      ST_ACCUM: begin
        // All three triggers latch the same length, so priority is moot here.
        if ((level >= MAX_LVL) || flush_pend || timeout_hit) begin
          state_next = ST_SEND;
          go_send    = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer_last) begin
          if (flush_pend && (level_after == '0)) state_next = ST_FLUSH;
          else if (level_after != '0)            state_next = ST_ACCUM;
          else                                   state_next = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        in_flush_now = 1'b1;
        state_next   = (level != '0) ? ST_ACCUM : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      timer      <= '0;
      cnt        <= '0;
    end else begin
      state <= state_next;

      if (state == ST_FLUSH)  flush_pend <= 1'b0;
      else if (s_flush)       flush_pend <= 1'b1;

      if (accept || ((state == ST_SEND) && (state_next != ST_SEND)))
        timer <= '0;
      else if ((state == ST_ACCUM) && (timer != TIMEOUT_V))
        timer <= timer + TMR_ONE;

      if (go_send)  cnt <= pkt_len;
      else if (rd)  cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_muacm_in_packer.sv
// Directed bench for muacm_in_packer: packet boundaries, timeout, flush,
// back-pressure, FIFO-full and mid-packet reset.
module tb_muacm_in_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_flush;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic       in_flush_now;
  logic       in_flush_time;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  logic [7:0]  got_d [$];
  logic        got_l [$];
  int unsigned got_cyc [$];
  int          flush_cnt = 0;
  int unsigned flush_cyc = 0;
  int unsigned acc_cyc   = 0;
  int          hold_err  = 0;

  logic [7:0]  src [$];
  logic [7:0]  ed [$];
  int          lasts [$];
  logic        flush_with_last;
  logic        rand_ready;

  muacm_in_packer #(
    .FIFO_LOG2  (8),
    .MAX_PKT    (64),
    .TIMEOUT    (100),
    .FLUSH_TIME (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_flush       (s_flush),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_flush_now  (in_flush_now),
    .in_flush_time (in_flush_time)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor samples on the falling edge; what it sees is what the next rising edge commits.
  initial begin : monitor
    logic       pv;
    logic [7:0] pd;
    logic       pl;
    pv = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !(in_valid && in_data == pd && in_last == pl)) hold_err++;
        if (in_valid && in_ready) begin
          got_d.push_back(in_data);
          got_l.push_back(in_last);
          got_cyc.push_back(cyc);
        end
        if (in_flush_now) begin
          flush_cnt++;
          flush_cyc = cyc;
        end
        if (s_valid && s_ready) acc_cyc = cyc;
        pv = in_valid && !in_ready;
        pd = in_data;
        pl = in_last;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) in_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic feed(input int budget);
    int   n;
    logic ok;
    n = 0;
    while (src.size() > 0 && n < budget) begin
      s_valid = 1'b1;
      s_data  = src[0];
      s_flush = flush_with_last && (src.size() == 1);
      ok      = s_ready;
      tick();
      if (ok) void'(src.pop_front());
      n++;
    end
    s_valid = 1'b0;
    s_flush = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n;
    n = 0;
    while (got_d.size() < target && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic check_pkt(input string tag, input int base);
    int   dm;
    int   lm;
    logic el;
    dm = 0;
    lm = 0;
    check({tag, "_count"}, got_d.size() - base, ed.size());
    for (int i = 0; i < ed.size(); i++) begin
      if (base + i < got_d.size()) begin
        el = 1'b0;
        foreach (lasts[k]) if (lasts[k] == i) el = 1'b1;
        if (got_d[base+i] !== ed[i]) dm++;
        if (got_l[base+i] !== el)    lm++;
      end
    end
    check({tag, "_data_errs"}, dm, 0);
    check({tag, "_last_errs"}, lm, 0);
  endtask

  initial begin
    int          base;
    int          fb;
    int          hb;
    int unsigned delta;

    rst             = 1'b1;
    s_valid         = 1'b0;
    s_data          = '0;
    s_flush         = 1'b0;
    in_ready        = 1'b0;
    rand_ready      = 1'b0;
    flush_with_last = 1'b0;

    repeat (3) tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_in_valid", in_valid, 0);
    check("rst_in_last", in_last, 0);
    check("rst_flush_now", in_flush_now, 0);
    rst = 1'b0;
    tick();
    check("s_ready_after_rst", s_ready, 1);
    check("flush_time", in_flush_time, 1);

    // 64 back-to-back bytes: one full packet, no flush
    in_ready = 1'b1;
    base = got_d.size();
    fb   = flush_cnt;
    ed.delete();
    lasts.delete();
    for (int i = 0; i < 64; i++) begin
      src.push_back(8'(i));
      ed.push_back(8'(i));
    end
    lasts.push_back(63);
    feed(200);
    wait_xfers(base + 64, 200);
    repeat (5) tick();
    check_pkt("t1", base);
    check("t1_no_flush", flush_cnt - fb, 0);

    // 3 bytes then idle: timeout closes the packet
    base = got_d.size();
    ed.delete();
    lasts.delete();
    src.push_back(8'hA1); src.push_back(8'hA2); src.push_back(8'hA3);
    ed.push_back(8'hA1);  ed.push_back(8'hA2);  ed.push_back(8'hA3);
    lasts.push_back(2);
    feed(20);
    wait_xfers(base + 3, 300);
    delta = got_cyc[base] - acc_cyc;
    check("t2_timeout_delay_ok", (delta >= 95 && delta <= 110), 1);
    repeat (5) tick();
    check_pkt("t2", base);

    // 5 bytes with s_flush on the last one
    base = got_d.size();
    fb   = flush_cnt;
    ed.delete();
    lasts.delete();
    for (int i = 0; i < 5; i++) begin
      src.push_back(8'(8'h10 + i));
      ed.push_back(8'(8'h10 + i));
    end
    lasts.push_back(4);
    flush_with_last = 1'b1;
    feed(20);
    flush_with_last = 1'b0;
    wait_xfers(base + 5, 300);
    repeat (5) tick();
    check_pkt("t3", base);
    check("t3_flush_pulses", flush_cnt - fb, 1);
    check("t3_flush_delay", flush_cyc - got_cyc[base+4], 1);

    // 300 bytes against a stalled sink: FIFO fills at 256
    in_ready = 1'b0;
    base = got_d.size();
    ed.delete();
    lasts.delete();
    for (int i = 0; i < 300; i++) begin
      src.push_back(8'((i * 37 + 5) & 255));
      ed.push_back(8'((i * 37 + 5) & 255));
    end
    lasts.push_back(63); lasts.push_back(127); lasts.push_back(191);
    lasts.push_back(255); lasts.push_back(299);
    feed(300);
    check("t4_accepted", 300 - src.size(), 256);
    check("t4_s_ready_full", s_ready, 0);
    check("t4_in_valid_stalled", in_valid, 1);
    check("t4_no_xfer_stalled", got_d.size() - base, 0);
    in_ready = 1'b1;
    feed(400);
    wait_xfers(base + 300, 1000);
    repeat (5) tick();
    check_pkt("t4", base);

    // 130 bytes with random sink stalls
    base = got_d.size();
    hb   = hold_err;
    ed.delete();
    lasts.delete();
    for (int i = 0; i < 130; i++) begin
      src.push_back(8'(i) ^ 8'h5A);
      ed.push_back(8'(i) ^ 8'h5A);
    end
    lasts.push_back(63); lasts.push_back(127); lasts.push_back(129);
    rand_ready = 1'b1;
    feed(400);
    wait_xfers(base + 130, 2000);
    rand_ready = 1'b0;
    in_ready   = 1'b1;
    repeat (5) tick();
    check_pkt("t5", base);
    check("t5_hold_errs", hold_err - hb, 0);

    // reset in the middle of a packet
    base = got_d.size();
    for (int i = 0; i < 64; i++) src.push_back(8'(8'h80 + i));
    feed(200);
    wait_xfers(base + 10, 200);
    rst = 1'b1;
    tick();
    check("t6_in_valid_after_rst", in_valid, 0);
    check("t6_in_last_after_rst", in_last, 0);
    check("t6_level_after_rst", dut.level, 0);
    check("t6_xfers_before_rst", got_d.size() - base, 10);
    src.delete();
    rst = 1'b0;
    tick();

    base = got_d.size();
    fb   = flush_cnt;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    repeat (10) tick();
    check("t6_empty_flush_pulses", flush_cnt - fb, 1);
    check("t6_empty_flush_no_data", got_d.size() - base, 0);

    base = got_d.size();
    ed.delete();
    lasts.delete();
    src.push_back(8'hC1); src.push_back(8'hC2);
    ed.push_back(8'hC1);  ed.push_back(8'hC2);
    lasts.push_back(1);
    feed(20);
    wait_xfers(base + 2, 300);
    repeat (5) tick();
    check_pkt("t6", base);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
